// File: rtl/uart_pkg.sv
// Shared UART transmitter types and default constants.
// Used by uart_baud_gen and uart_tx_frame.
package uart_pkg;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = DATA_BITS + 1;
    localparam int DT_TICKS   = 16;
    localparam int SP_TICKS   = 16;
    localparam int DIVSR_W    = 10;
    localparam int DIVSR_DEF  = 650;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud tick generator: one tick every divsr clocks.
// Counter held at zero while clr is high; divsr of 0 or 1 ticks every clock.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int W = DIVSR_W
) (
    input  logic         clk,
    input  logic         Reset,
    input  logic         clr,
    input  logic [W-1:0] divsr,
    output logic         tick
);

    logic [W-1:0] cnt_q;
    logic         wrap;

    assign wrap = (divsr <= W'(1)) || (cnt_q == divsr - W'(1));
    assign tick = wrap && !clr;

    // Divisor counter, restarts on clear or on each tick
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            cnt_q <= '0;
        end else if (clr || wrap) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start, 8 data bits LSB first, optional even parity, stop.
// Define UART_TX_PARITY_EN to compile in the parity bit (11-bit frame).
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int Data_bits   = FRAME_BITS,
    parameter int Dt_ticks    = DT_TICKS,
    parameter int Sp_ticks    = SP_TICKS,
    parameter int divsr_width = DIVSR_W
) (
    input  logic                   clk,
    input  logic                   Reset,
    input  logic [divsr_width-1:0] divsr,
    input  logic                   tx_start,
    input  logic [Data_bits-2:0]   din,
    output logic                   tx_ready,
    output logic                   tx,
    output logic                   tx_done_tick
);

    localparam int DW   = Data_bits - 1;
    localparam int TMAX = (Dt_ticks > Sp_ticks) ? Dt_ticks : Sp_ticks;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int NW   = (DW > 1) ? $clog2(DW) : 1;

    localparam logic [TW-1:0] DT_LAST = TW'(Dt_ticks - 1);
    localparam logic [TW-1:0] SP_LAST = TW'(Sp_ticks - 1);
    localparam logic [NW-1:0] N_LAST  = NW'(DW - 1);

    tx_state_e              state_q, state_d;
    logic [TW-1:0]          s_q, s_d;
    logic [NW-1:0]          n_q, n_d;
    logic [DW-1:0]          b_q, b_d;
    logic [divsr_width-1:0] divsr_q, divsr_d;
    logic                   tx_q, tx_d;
    logic                   done_q, done_d;
    logic                   tick;
    logic                   clr;
`ifdef UART_TX_PARITY_EN
    logic                   par_q, par_d;
`endif

    assign clr          = (state_q == IDLE);
    assign tx_ready     = (state_q == IDLE);
    assign tx           = tx_q;
    assign tx_done_tick = done_q;

    uart_baud_gen #(
        .W(divsr_width)
    ) u_baud (
        .clk  (clk),
        .Reset(Reset),
        .clr  (clr),
        .divsr(divsr_q),
        .tick (tick)
    );

    // State, counters, shift register and registered line outputs
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            divsr_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            divsr_q <= divsr_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state, bit sequencing and next line value
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        divsr_d = divsr_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (tx_start) begin
                    state_d = START;
                    s_d     = '0;
                    n_d     = '0;
                    b_d     = din;
                    divsr_d = divsr;
                    tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^din;
`endif
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == DT_LAST) begin
                        state_d = DATA;
                        s_d     = '0;
                        n_d     = '0;
                        tx_d    = b_q[0];
                    end else begin
                        s_d = s_q + TW'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == DT_LAST) begin
                        s_d = '0;
                        b_d = b_q >> 1;
                        if (n_q == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_d = PARITY;
                            tx_d    = par_q;
`else
                            state_d = STOP;
                            tx_d    = 1'b1;
`endif
                        end else begin
                            n_d  = n_q + NW'(1);
                            tx_d = b_d[0];
                        end
                    end else begin
                        s_d = s_q + TW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (s_q == DT_LAST) begin
                        state_d = STOP;
                        s_d     = '0;
                        tx_d    = 1'b1;
                    end else begin
                        s_d = s_q + TW'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (s_q == SP_LAST) begin
                        state_d = IDLE;
                        s_d     = '0;
                        tx_d    = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        s_d = s_q + TW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                s_d     = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: bit timing, framing, parity,
// back-to-back frames, ignored mid-frame requests and async reset.
module tb_uart_tx_frame;

    localparam int DT = 16;

    logic       clk;
    logic       Reset;
    logic [9:0] divsr;
    logic       tx_start;
    logic [7:0] din;
    logic       tx_ready;
    logic       tx;
    logic       tx_done_tick;

    int n_vec;
    int n_err;

    uart_tx_frame dut (
        .clk         (clk),
        .Reset       (Reset),
        .divsr       (divsr),
        .tx_start    (tx_start),
        .din         (din),
        .tx_ready    (tx_ready),
        .tx          (tx),
        .tx_done_tick(tx_done_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request and let one edge accept it
    task automatic accept(input logic [7:0] d, input int div, input bit hold);
        din      = d;
        divsr    = 10'(div);
        tx_start = 1'b1;
        check("ready_at_accept", tx_ready, 1);
        step();
        if (!hold) tx_start = 1'b0;
    endtask

    // Called in the first cycle after accept; ends after the STOP->IDLE edge
    task automatic run_frame(input logic [7:0] d, input int div,
                             input bit disturb);
        int   l;
        int   nb;
        int   t;
        logic fb [11];
        l = DT * ((div <= 1) ? 1 : div);
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
        fb[9]  = ^d;
        fb[10] = 1'b1;
        nb     = 11;
`else
        fb[9]  = 1'b1;
        fb[10] = 1'b1;
        nb     = 10;
`endif
        t = nb * l;
        for (int c = 0; c < t; c++) begin
            if (c == 0) check("busy", tx_ready, 0);
            if ((c % l == 0) || (c % l == l - 1))
                check($sformatf("bit%0d_c%0d", c / l, c % l), tx, fb[c/l]);
            if (c == t - 1) check("done_early", tx_done_tick, 0);
            if (disturb && c == 4 * l) begin
                din      = ~d;
                divsr    = divsr + 10'd3;
                tx_start = 1'b1;
            end
            if (disturb && c == 4 * l + 1) tx_start = 1'b0;
            step();
        end
        check("done", tx_done_tick, 1);
        check("ready_after", tx_ready, 1);
        check("idle_tx", tx, 1);
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        Reset    = 1'b0;
        divsr    = '0;
        tx_start = 1'b0;
        din      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", tx, 1);
        check("rst_ready", tx_ready, 1);
        check("rst_done", tx_done_tick, 0);
        @(negedge clk);
        Reset = 1'b1;

        // First edge after release accepts; divsr=1, din=0
        accept(8'h00, 1, 0);
        run_frame(8'h00, 1, 0);
        step();
        check("done_one_cycle", tx_done_tick, 0);

        // divsr=0 also ticks every clock
        accept(8'hE3, 0, 0);
        run_frame(8'hE3, 0, 0);
        step();

        // Multi-clock baud, parity-zero and parity-one payloads
        accept(8'hE3, 3, 0);
        run_frame(8'hE3, 3, 0);
        step();
        accept(8'hF0, 2, 0);
        run_frame(8'hF0, 2, 0);
        step();

        // Held request: A5 then 5A with one idle-high cycle between
        accept(8'hA5, 2, 1);
        din = 8'h5A;
        run_frame(8'hA5, 2, 0);
        step();
        check("b2b_start", tx, 0);
        tx_start = 1'b0;
        run_frame(8'h5A, 2, 0);
        step();
        check("b2b_done_low", tx_done_tick, 0);

        // Request during DATA ignored; din/divsr changes do not leak in
        accept(8'h96, 2, 0);
        run_frame(8'h96, 2, 1);
        step();
        for (int i = 0; i < 40; i++) begin
            if (i % 10 == 0) begin
                check("no_requeue_tx", tx, 1);
                check("no_requeue_rdy", tx_ready, 1);
                check("no_requeue_done", tx_done_tick, 0);
            end
            step();
        end

        // Async reset during data bit 3
        accept(8'h3C, 2, 0);
        repeat (DT * 2 * 4 + 5) step();
        check("mid_busy", tx_ready, 0);
        Reset = 1'b0;
        #1;
        check("arst_tx", tx, 1);
        check("arst_ready", tx_ready, 1);
        check("arst_done", tx_done_tick, 0);
        @(negedge clk);
        Reset = 1'b1;
        accept(8'h81, 1, 0);
        run_frame(8'h81, 1, 0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
